l2_request_arbiter: RTL and testbench
=====================================

# l2_request_arbiter

Shares the single L2 memory request port between NUM_REQ requesters (I-cache, D-cache, DMA-style masters) and sits in front of the AXI bridge that consumes the l2 slave port. It grants one request at a time and holds the grant until the bridge has popped the request and drained all write-data beats. Arbitration is round-robin by default. The block routes read responses back to the owning requester using the upper bits of the returned ID.

## Interface
Parameters:
- NUM_REQ, default 2: number of requesters, 2..4.
- SUB_ID_W, default 1: per-requester ID bits.
- ID_W, default $clog2(NUM_REQ)+SUB_ID_W: downstream ID width.

Ports (per-requester signals are packed arrays indexed [NUM_REQ-1:0]):
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  request pending; held until req_pop.
- req_addr  in  NUM_REQ×30  word address.
- req_rnw  in  NUM_REQ  1 = read.
- req_be  in  NUM_REQ×4  byte enables.
- req_is_amo  in  NUM_REQ  atomic op.
- req_amo_type_or_burst_size  in  NUM_REQ×5  AMO op or burst length minus one.
- req_sub_id  in  NUM_REQ×SUB_ID_W  requester-local ID.
- req_wr_data  in  NUM_REQ×32  write data head.
- req_wr_data_valid  in  NUM_REQ  write data available.
- req_pop  out  NUM_REQ  request accepted downstream.
- req_wr_data_read  out  NUM_REQ  write beat consumed.
- req_rd_data  out  32  read data, broadcast to all requesters.
- req_rd_data_valid  out  NUM_REQ  read beat for requester i.
- req_rd_sub_id  out  SUB_ID_W  lower bits of rd_id.
- l2_request_valid, l2_addr, l2_rnw, l2_be, l2_is_amo, l2_amo_type_or_burst_size, l2_wr_data, l2_wr_data_valid  out  (widths as above)  muxed from the granted requester.
- l2_id  out  ID_W  {grant index, req_sub_id}.
- l2_request_pop  in  1  bridge accepted the request.
- l2_wr_data_read  in  1  bridge consumed a write beat.
- l2_rd_data  in  32; l2_rd_id  in  ID_W; l2_rd_data_valid  in  1.

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick a winner, register grant_idx and move to GRANT.
  - Load beats_left: burst_size+1 for a non-AMO write, 1 for an AMO, 0 for a plain read.
  - Clear the popped flag.
- Round-robin search starts at last_grant+1 modulo NUM_REQ. last_grant updates on every grant.
- GRANT:
  - l2_* outputs carry the granted requester's fields. l2_request_valid = req_valid[grant_idx].
  - l2_request_pop is forwarded to req_pop[grant_idx] only. It sets popped.
  - l2_wr_data_read is forwarded to req_wr_data_read[grant_idx] only. It decrements beats_left; beats_left saturates at 0.
  - Exit to IDLE in the cycle where popped (or pop this cycle) holds and beats_left is 0 (or reaches 0 this cycle).
- In IDLE all l2_* outputs are 0, except l2_rd-path passthrough.
- Response demux is independent of state:
  - req_rd_data_valid[i] = l2_rd_data_valid and l2_rd_id[ID_W-1:SUB_ID_W] == i.
  - Out-of-range index: no valid asserted.
- A pop or data_read arriving in IDLE is ignored. A checker assertion fires on it.

## Timing
- Reset: state IDLE, last_grant = NUM_REQ-1 (requester 0 wins first), beats_left 0, popped 0.
- Reset: every req_pop, req_wr_data_read and l2_request_valid output is 0.
- Reset asserted mid-transfer aborts immediately. There is no drain.
- Arbitration latency: req_valid seen at cycle t gives l2_request_valid at t+1.
- Minimum of one IDLE bubble between consecutive grants.
- req_pop and req_wr_data_read are combinational passthroughs: zero cycles added.
- Read response path is fully combinational: zero latency.
- Pop and last data beat in the same cycle: exit to IDLE next cycle.
- A requester dropping req_valid before its pop is a protocol violation. A checker assertion fires on it.

## Configuration
- L2_REQUEST_ARBITER_FIXED_PRIORITY_EN:
  - Defined: lowest index always wins, and last_grant is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Both requesters assert reads out of reset:
  - Req 0 is granted at cycle 1 with l2_id={0,sub}.
  - After the pop, IDLE bubble, then req 1 is granted.
- Req 0 writes with burst_size=3:
  - The grant holds for 4 l2_wr_data_read pulses even though the pop arrives after the first beat.
  - Req 1 is not granted until the 4th beat.
- Round-robin: requesters 0,1 continuously valid for 6 transactions → grant sequence 0,1,0,1,0,1.
  - With the macro defined the sequence is 0,0,0,0,0,0.
- AMO from req 1:
  - beats_left=1; the pop arrives after the read-modify-write.
  - Exit occurs in the cycle after the single beat and the pop.
- Read responses: l2_rd_id=2'b10 with valid → only req_rd_data_valid[1]=1 and req_rd_sub_id=0.
- Async reset asserted mid-burst at beat 2 → state IDLE and all pops/reads 0 within the same cycle.
  - After reset release, req 0 is granted first.

Source files
------------

// File: rtl/l2_request_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single L2 request port and demuxes read responses by ID.
// Define L2_REQUEST_ARBITER_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
module l2_request_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int SUB_ID_W = 1,
   parameter int ID_W     = $clog2(NUM_REQ) + SUB_ID_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0][29:0]         req_addr,
   input  logic [NUM_REQ-1:0]               req_rnw,
   input  logic [NUM_REQ-1:0][3:0]          req_be,
   input  logic [NUM_REQ-1:0]               req_is_amo,
   input  logic [NUM_REQ-1:0][4:0]          req_amo_type_or_burst_size,
   input  logic [NUM_REQ-1:0][SUB_ID_W-1:0] req_sub_id,
   input  logic [NUM_REQ-1:0][31:0]         req_wr_data,
   input  logic [NUM_REQ-1:0]               req_wr_data_valid,
   output logic [NUM_REQ-1:0]               req_pop,
   output logic [NUM_REQ-1:0]               req_wr_data_read,
   output logic [31:0]                      req_rd_data,
   output logic [NUM_REQ-1:0]               req_rd_data_valid,
   output logic [SUB_ID_W-1:0]              req_rd_sub_id,
   output logic                             l2_request_valid,
   output logic [29:0]                      l2_addr,
   output logic                             l2_rnw,
   output logic [3:0]                       l2_be,
   output logic                             l2_is_amo,
   output logic [4:0]                       l2_amo_type_or_burst_size,
   output logic [31:0]                      l2_wr_data,
   output logic                             l2_wr_data_valid,
   output logic [ID_W-1:0]                  l2_id,
   input  logic                             l2_request_pop,
   input  logic                             l2_wr_data_read,
   input  logic [31:0]                      l2_rd_data,
   input  logic [ID_W-1:0]                  l2_rd_id,
   input  logic                             l2_rd_data_valid
);
   localparam int          IDX_W = $clog2(NUM_REQ);
   localparam int unsigned NR    = NUM_REQ;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] grant_idx;
   logic [IDX_W-1:0] winner;
   logic             winner_found;
   logic [5:0]       beats_left, beats_next, beats_load;
   logic             popped, popped_next;

`ifdef L2_REQUEST_ARBITER_FIXED_PRIORITY_EN
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (!winner_found && req_valid[i]) begin
            winner       = IDX_W'(i);
            winner_found = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] cand;

   // Search begins one past the previous winner so every requester gets a turn.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      cand         = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         cand = IDX_W'((32'(last_grant) + k) % NR);
         if (!winner_found && req_valid[cand]) begin
            winner       = cand;
            winner_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= IDX_W'(NUM_REQ - 1);
      else if (state == IDLE && winner_found)
         last_grant <= winner;
   end
`endif

   always_comb begin
      if (req_is_amo[winner])
         beats_load = 6'd1;
      else if (req_rnw[winner])
         beats_load = '0;
      else
         beats_load = {1'b0, req_amo_type_or_burst_size[winner]} + 6'd1;
   end

   always_comb begin
      state_next  = state;
      beats_next  = beats_left;
      popped_next = popped;
      case (state)
         IDLE: begin
            popped_next = 1'b0;
            if (winner_found) begin
               beats_next = beats_load;
               state_next = GRANT;
            end
         end
         GRANT: begin
            popped_next = popped | l2_request_pop;
            if (l2_wr_data_read && beats_left != '0)
               beats_next = beats_left - 6'd1;
            if (popped_next && beats_next == '0)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant_idx  <= '0;
         beats_left <= '0;
         popped     <= 1'b0;
      end else begin
         state      <= state_next;
         beats_left <= beats_next;
         popped     <= popped_next;
         if (state == IDLE && winner_found)
            grant_idx <= winner;
      end
   end

   always_comb begin
      req_pop                   = '0;
      req_wr_data_read          = '0;
      l2_request_valid          = 1'b0;
      l2_addr                   = '0;
      l2_rnw                    = 1'b0;
      l2_be                     = '0;
      l2_is_amo                 = 1'b0;
      l2_amo_type_or_burst_size = '0;
      l2_wr_data                = '0;
      l2_wr_data_valid          = 1'b0;
      l2_id                     = '0;
      if (state == GRANT) begin
         req_pop[grant_idx]          = l2_request_pop;
         req_wr_data_read[grant_idx] = l2_wr_data_read;
         l2_request_valid            = req_valid[grant_idx];
         l2_addr                     = req_addr[grant_idx];
         l2_rnw                      = req_rnw[grant_idx];
         l2_be                       = req_be[grant_idx];
         l2_is_amo                   = req_is_amo[grant_idx];
         l2_amo_type_or_burst_size   = req_amo_type_or_burst_size[grant_idx];
         l2_wr_data                  = req_wr_data[grant_idx];
         l2_wr_data_valid            = req_wr_data_valid[grant_idx];
         l2_id                       = ID_W'({grant_idx, req_sub_id[grant_idx]});
      end
   end

   // Indices beyond NUM_REQ-1 match no requester, so no valid is raised for them.
   always_comb begin
      req_rd_data_valid = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (l2_rd_data_valid && 32'(l2_rd_id[ID_W-1:SUB_ID_W]) == i)
            req_rd_data_valid[i] = 1'b1;
      end
   end

   assign req_rd_data   = l2_rd_data;
   assign req_rd_sub_id = l2_rd_id[SUB_ID_W-1:0];

   ap_no_idle_handshake: assert property (@(posedge clk) disable iff (rst)
      (state == IDLE) |-> !(l2_request_pop || l2_wr_data_read));

   ap_valid_held_until_pop: assert property (@(posedge clk) disable iff (rst)
      (state == GRANT && !popped) |-> req_valid[grant_idx]);

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed + randomized bench for l2_request_arbiter; the bench plays both the requesters and the bridge.
// Honours L2_REQUEST_ARBITER_FIXED_PRIORITY_EN when computing expected grant order.
module tb_l2_request_arbiter;
   localparam int N  = 2;
   localparam int SW = 1;
   localparam int IW = $clog2(N) + SW;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0][29:0]   req_addr;
   logic [N-1:0]         req_rnw;
   logic [N-1:0][3:0]    req_be;
   logic [N-1:0]         req_is_amo;
   logic [N-1:0][4:0]    req_amo_type_or_burst_size;
   logic [N-1:0][SW-1:0] req_sub_id;
   logic [N-1:0][31:0]   req_wr_data;
   logic [N-1:0]         req_wr_data_valid;
   logic [N-1:0]         req_pop;
   logic [N-1:0]         req_wr_data_read;
   logic [31:0]          req_rd_data;
   logic [N-1:0]         req_rd_data_valid;
   logic [SW-1:0]        req_rd_sub_id;
   logic                 l2_request_valid;
   logic [29:0]          l2_addr;
   logic                 l2_rnw;
   logic [3:0]           l2_be;
   logic                 l2_is_amo;
   logic [4:0]           l2_amo_type_or_burst_size;
   logic [31:0]          l2_wr_data;
   logic                 l2_wr_data_valid;
   logic [IW-1:0]        l2_id;
   logic                 l2_request_pop;
   logic                 l2_wr_data_read;
   logic [31:0]          l2_rd_data;
   logic [IW-1:0]        l2_rd_id;
   logic                 l2_rd_data_valid;

   int errs   = 0;
   int checks = 0;
   int model_last;
   int grants[$];

   l2_request_arbiter #(.NUM_REQ(N), .SUB_ID_W(SW), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_rnw(req_rnw), .req_be(req_be),
      .req_is_amo(req_is_amo), .req_amo_type_or_burst_size(req_amo_type_or_burst_size),
      .req_sub_id(req_sub_id), .req_wr_data(req_wr_data), .req_wr_data_valid(req_wr_data_valid),
      .req_pop(req_pop), .req_wr_data_read(req_wr_data_read), .req_rd_data(req_rd_data),
      .req_rd_data_valid(req_rd_data_valid), .req_rd_sub_id(req_rd_sub_id),
      .l2_request_valid(l2_request_valid), .l2_addr(l2_addr), .l2_rnw(l2_rnw), .l2_be(l2_be),
      .l2_is_amo(l2_is_amo), .l2_amo_type_or_burst_size(l2_amo_type_or_burst_size),
      .l2_wr_data(l2_wr_data), .l2_wr_data_valid(l2_wr_data_valid), .l2_id(l2_id),
      .l2_request_pop(l2_request_pop), .l2_wr_data_read(l2_wr_data_read),
      .l2_rd_data(l2_rd_data), .l2_rd_id(l2_rd_id), .l2_rd_data_valid(l2_rd_data_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: scan pending requesters starting after the previous winner.
   function automatic int pick();
`ifdef L2_REQUEST_ARBITER_FIXED_PRIORITY_EN
      for (int i = 0; i < N; i++)
         if (req_valid[i]) return i;
`else
      for (int k = 1; k <= N; k++)
         if (req_valid[(model_last + k) % N]) return (model_last + k) % N;
`endif
      return -1;
   endfunction

   task automatic start_req(input int r, input bit rnw, input bit amo, input int size);
      req_valid[r]                  = 1'b1;
      req_rnw[r]                    = rnw;
      req_is_amo[r]                 = amo;
      req_amo_type_or_burst_size[r] = 5'(size);
      req_addr[r]                   = 30'($urandom_range(1, 32'h3fff_ffff));
      req_be[r]                     = 4'($urandom);
      req_sub_id[r]                 = SW'($urandom);
      req_wr_data[r]                = $urandom;
      req_wr_data_valid[r]          = !rnw || amo;
   endtask

   task automatic rand_req(input int r);
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0)      start_req(r, 1'b1, 1'b0, $urandom_range(0, 7));
      else if (kind == 1) start_req(r, 1'b0, 1'b0, $urandom_range(0, 7));
      else                start_req(r, 1'(($urandom_range(0, 1))), 1'b1, $urandom_range(0, 31));
   endtask

   task automatic rd_check(input string tag, input int id, input bit v);
      int idx;
      logic [31:0] d;
      d = $urandom;
      l2_rd_id = IW'(id);
      l2_rd_data_valid = v;
      l2_rd_data = d;
      #1;
      idx = id >> SW;
      chk({tag, "_rd_valid"}, req_rd_data_valid, (v && idx < N) ? (64'd1 << idx) : 64'd0);
      chk({tag, "_rd_sub"}, req_rd_sub_id, id % (1 << SW));
      chk({tag, "_rd_data"}, req_rd_data, d);
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge after the grant has ended.
   task automatic do_grant(input int pop_at_in);
      int o, beats, done, pop_at, cyc;
      bit popped, pop_d, rd_d;
      o = pick();
      if (o < 0) begin
         checks++; errs++;
         $display("FAIL no_pending observed=none expected=a pending requester");
         return;
      end
      #1;
      chk("bubble_valid", l2_request_valid, 0);
      chk("bubble_addr", l2_addr, 0);
      chk("bubble_wdv", l2_wr_data_valid, 0);
      @(negedge clk);
      model_last = o;
      grants.push_back(o);
      #1;
      chk("grant_valid", l2_request_valid, 1);
      chk("grant_id", l2_id, (o << SW) | int'(req_sub_id[o]));
      chk("grant_addr", l2_addr, req_addr[o]);
      chk("grant_rnw", l2_rnw, req_rnw[o]);
      chk("grant_be", l2_be, req_be[o]);
      chk("grant_amo", l2_is_amo, req_is_amo[o]);
      chk("grant_size", l2_amo_type_or_burst_size, req_amo_type_or_burst_size[o]);
      chk("grant_wdata", l2_wr_data, req_wr_data[o]);
      beats = req_is_amo[o] ? 1 : (req_rnw[o] ? 0 : int'(req_amo_type_or_burst_size[o]) + 1);
      pop_at = (pop_at_in < 0) ? $urandom_range(0, beats) : pop_at_in;
      done = 0;
      popped = 1'b0;
      cyc = 0;
      while (!(popped && done == beats)) begin
         pop_d = !popped && done >= pop_at && $urandom_range(0, 3) != 0;
         rd_d  = done < beats && $urandom_range(0, 2) != 0;
         l2_request_pop  = pop_d;
         l2_wr_data_read = rd_d;
         rd_check("busy", $urandom_range(0, (1 << IW) - 1), 1'($urandom_range(0, 1)));
         chk("busy_pop", req_pop, pop_d ? (64'd1 << o) : 64'd0);
         chk("busy_wdr", req_wr_data_read, rd_d ? (64'd1 << o) : 64'd0);
         chk("busy_id", l2_id, (o << SW) | int'(req_sub_id[o]));
         @(negedge clk);
         l2_request_pop  = 1'b0;
         l2_wr_data_read = 1'b0;
         if (pop_d) begin
            popped = 1'b1;
            req_valid[o] = 1'b0;
         end
         if (rd_d) done++;
         cyc++;
         if (cyc > 300) begin
            checks++; errs++;
            $display("FAIL txn_timeout observed=%0d cycles expected=completion", cyc);
            break;
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1;
      req_valid = '0; req_addr = '0; req_rnw = '0; req_be = '0; req_is_amo = '0;
      req_amo_type_or_burst_size = '0; req_sub_id = '0; req_wr_data = '0; req_wr_data_valid = '0;
      l2_request_pop = 1'b0; l2_wr_data_read = 1'b0;
      l2_rd_data = '0; l2_rd_id = '0; l2_rd_data_valid = 1'b0;

      // Reset: outputs gated even with pending reads and bridge strobes high.
      start_req(0, 1'b1, 1'b0, 0);
      start_req(1, 1'b1, 1'b0, 0);
      @(negedge clk);
      l2_request_pop = 1'b1; l2_wr_data_read = 1'b1;
      #1;
      chk("rst_pop", req_pop, 0);
      chk("rst_wdr", req_wr_data_read, 0);
      chk("rst_valid", l2_request_valid, 0);
      chk("rst_addr", l2_addr, 0);
      @(negedge clk);
      l2_request_pop = 1'b0; l2_wr_data_read = 1'b0;
      rst = 1'b0;
      model_last = N - 1;

      // Both reads out of reset: 0 then 1.
      do_grant(-1);
      do_grant(-1);
      chk("first_two", {grants[0][7:0], grants[1][7:0]}, 16'h0001);

      // Write burst of 4 from req 0, pop after the first beat, req 1 read waiting.
      start_req(0, 1'b0, 1'b0, 3);
      start_req(1, 1'b1, 1'b0, 5);
      do_grant(1);
      do_grant(-1);

      // Both continuously valid for 6 transactions.
      rand_req(0);
      rand_req(1);
      base = grants.size();
      for (int t = 0; t < 6; t++) begin
         do_grant(-1);
         rand_req(grants[grants.size() - 1]);
      end
      for (int t = 0; t < 6; t++) begin
`ifdef L2_REQUEST_ARBITER_FIXED_PRIORITY_EN
         chk("rr_seq", grants[base + t], 0);
`else
         chk("rr_seq", grants[base + t], t % 2);
`endif
      end
      for (int t = 0; t < 4 && req_valid != '0; t++) do_grant(-1);

      // AMO from req 1: one beat, pop strictly after it.
      start_req(1, 1'b0, 1'b1, 9);
      do_grant(1);

      // Read response demux, including the 2'b10 case.
      rd_check("rd10", 2, 1'b1);
      for (int t = 0; t < 8; t++)
         rd_check("rdr", $urandom_range(0, (1 << IW) - 1), 1'($urandom_range(0, 1)));
      l2_rd_data_valid = 1'b0;

      // Randomized traffic.
      for (int t = 0; t < 20; t++) begin
         for (int r = 0; r < N; r++)
            if (!req_valid[r] && $urandom_range(0, 1) != 0) rand_req(r);
         if (req_valid == '0) rand_req($urandom_range(0, N - 1));
         do_grant(-1);
      end

      // Async reset in the middle of a burst, at the second beat.
      start_req(0, 1'b0, 1'b0, 3);
      @(negedge clk);
      #1;
      chk("mid_grant_id", l2_id[IW-1:SW], pick());
      l2_wr_data_read = 1'b1;
      #1;
      chk("mid_beat1", req_wr_data_read, 1);
      @(negedge clk);
      #1;
      chk("mid_beat2", req_wr_data_read, 1);
      l2_request_pop = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("arst_wdr", req_wr_data_read, 0);
      chk("arst_pop", req_pop, 0);
      chk("arst_valid", l2_request_valid, 0);
      chk("arst_addr", l2_addr, 0);
      @(negedge clk);
      l2_request_pop = 1'b0; l2_wr_data_read = 1'b0;
      start_req(0, 1'b1, 1'b0, 0);
      start_req(1, 1'b1, 1'b0, 0);
      rst = 1'b0;
      model_last = N - 1;
      base = grants.size();
      do_grant(-1);
      do_grant(-1);
      chk("post_rst_first", grants[base], 0);
      #1;
      chk("final_idle", l2_request_valid, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
